// File: rtl/i8080_pkg.sv
// rtl/i8080_pkg.sv - shared constants and pair-operation encoding for the register pair file
package i8080_pkg;

  localparam int WIDTH_DEF = 8;

  localparam int PAIR_BC = 0;
  localparam int PAIR_DE = 1;
  localparam int PAIR_HL = 2;
  localparam int PAIR_WZ = 3;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_LOAD,
    OP_INC,
    OP_DEC,
    OP_XCHG
  } pair_op_e;

endpackage

// File: rtl/reg_pair.sv
// rtl/reg_pair.sv - one 16-bit register pair with load, inc/dec and per-byte write enables
module reg_pair #(
  parameter int WIDTH = 8
) (
  input  logic               clk50M_i,
  input  logic               rst_ni,
  input  logic               load_i,
  input  logic [2*WIDTH-1:0] load_d_i,
  input  logic               inc_i,
  input  logic               dec_i,
  input  logic               hi_we_i,
  input  logic               lo_we_i,
  input  logic [WIDTH-1:0]   byte_d_i,
  output logic [2*WIDTH-1:0] q_o
);

  localparam int            DW  = 2 * WIDTH;
  localparam logic [DW-1:0] ONE = {{(DW-1){1'b0}}, 1'b1};

  logic [DW-1:0] q_q, q_d;

  // Whole-pair operations take precedence; byte enables only arrive when no pair op targets this pair.
  always_comb begin
    q_d = q_q;
    if (load_i) begin
      q_d = load_d_i;
    end else if (inc_i) begin
      q_d = q_q + ONE;
    end else if (dec_i) begin
      q_d = q_q - ONE;
    end else begin
      if (hi_we_i) q_d[DW-1:WIDTH] = byte_d_i;
      if (lo_we_i) q_d[WIDTH-1:0]  = byte_d_i;
    end
  end

  // Pair storage, cleared immediately by reset.
  always_ff @(posedge clk50M_i or negedge rst_ni) begin
    if (!rst_ni) q_q <= '0;
    else         q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/reg_pair_file.sv
// rtl/reg_pair_file.sv - register pair file with byte bus access, pair ops, priority and collision detect
module reg_pair_file
  import i8080_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int NUM_PAIRS = 4
) (
  input  logic                           clk50M_i,
  input  logic                           rst_ni,
  input  logic [$clog2(2*NUM_PAIRS)-1:0] sel_i,
  input  logic                           rd_i,
  input  logic                           wr_i,
  inout  wire  [WIDTH-1:0]               bus_io,
  input  logic [$clog2(NUM_PAIRS)-1:0]   pair_sel_i,
  input  logic                           pair_wr_i,
  input  logic [2*WIDTH-1:0]             pair_d_i,
  input  logic                           inc_i,
  input  logic                           dec_i,
  input  logic                           xchg_i,
  output logic [2*WIDTH-1:0]             pair_o,
  output logic                           zero_o,
  output logic                           collision_o
);

  localparam int            SW       = $clog2(2*NUM_PAIRS);
  localparam int            PW       = $clog2(NUM_PAIRS);
  localparam int            DW       = 2 * WIDTH;
  localparam logic [DW-1:0] ONE      = {{(DW-1){1'b0}}, 1'b1};
  localparam bit            HAS_XCHG = NUM_PAIRS > PAIR_HL;

  logic [DW-1:0]        pair_q [NUM_PAIRS];
  logic [PW-1:0]        byte_pair;
  logic                 byte_hi;
  logic                 sel_ok, pair_ok, wr_en;
  pair_op_e             op;
  logic [NUM_PAIRS-1:0] touched, load_en, inc_en, dec_en, hi_we, lo_we;
  logic [DW-1:0]        tgt_word, step_res, rd_word;
  logic [WIDTH-1:0]     rd_byte;
  logic                 zero_q, zero_d, collision_q, collision_d;

  assign byte_pair = sel_i[SW-1:1];
  assign byte_hi   = ~sel_i[0];
  assign sel_ok    = int'(byte_pair) < NUM_PAIRS;
  assign pair_ok   = int'(pair_sel_i) < NUM_PAIRS;
  assign wr_en     = wr_i && !rd_i && sel_ok && pair_ok;

  // Pick the single executing pair operation by priority; out-of-range selects disable everything.
  always_comb begin
    op = OP_NONE;
    if (sel_ok && pair_ok) begin
      if (pair_wr_i)              op = OP_LOAD;
      else if (inc_i)             op = OP_INC;
      else if (dec_i)             op = OP_DEC;
      else if (xchg_i && HAS_XCHG) op = OP_XCHG;
    end
  end

  // Per-pair enables; a byte write into a pair the operation touches is dropped.
  always_comb begin
    touched = '0;
    load_en = '0;
    inc_en  = '0;
    dec_en  = '0;
    hi_we   = '0;
    lo_we   = '0;
    for (int i = 0; i < NUM_PAIRS; i++) begin
      load_en[i] = (op == OP_LOAD && pair_sel_i == PW'(i)) ||
                   (op == OP_XCHG && (i == PAIR_DE || i == PAIR_HL));
      inc_en[i]  = op == OP_INC && pair_sel_i == PW'(i);
      dec_en[i]  = op == OP_DEC && pair_sel_i == PW'(i);
      touched[i] = load_en[i] || inc_en[i] || dec_en[i];
      hi_we[i]   = wr_en && byte_pair == PW'(i) && byte_hi && !touched[i];
      lo_we[i]   = wr_en && byte_pair == PW'(i) && !byte_hi && !touched[i];
    end
  end

  for (genvar g = 0; g < NUM_PAIRS; g++) begin : g_pair
    localparam int OTHER = !HAS_XCHG ? g : ((g == PAIR_DE) ? PAIR_HL : PAIR_DE);
    logic [DW-1:0] load_d;
    assign load_d = (op == OP_XCHG) ? pair_q[OTHER] : pair_d_i;

    reg_pair #(.WIDTH(WIDTH)) u_pair (
      .clk50M_i (clk50M_i),
      .rst_ni   (rst_ni),
      .load_i   (load_en[g]),
      .load_d_i (load_d),
      .inc_i    (inc_en[g]),
      .dec_i    (dec_en[g]),
      .hi_we_i  (hi_we[g]),
      .lo_we_i  (lo_we[g]),
      .byte_d_i (bus_io),
      .q_o      (pair_q[g])
    );
  end

  // Target pair view, inc/dec result for the zero flag, and byte read mux.
  always_comb begin
    tgt_word    = pair_ok ? pair_q[pair_sel_i] : '0;
    step_res    = (op == OP_DEC) ? tgt_word - ONE : tgt_word + ONE;
    zero_d      = (op == OP_INC || op == OP_DEC) ? (step_res == '0) : zero_q;
    collision_d = wr_en && touched[byte_pair];
    rd_word     = sel_ok ? pair_q[byte_pair] : '0;
    rd_byte     = byte_hi ? rd_word[DW-1:WIDTH] : rd_word[WIDTH-1:0];
  end

  // Zero flag holds except on inc/dec; collision is a single-cycle pulse.
  always_ff @(posedge clk50M_i or negedge rst_ni) begin
    if (!rst_ni) begin
      zero_q      <= 1'b0;
      collision_q <= 1'b0;
    end else begin
      zero_q      <= zero_d;
      collision_q <= collision_d;
    end
  end

  assign bus_io      = (rd_i && rst_ni) ? rd_byte : {WIDTH{1'bz}};
  assign pair_o      = tgt_word;
  assign zero_o      = zero_q;
  assign collision_o = collision_q;

endmodule

// File: tb/tb_reg_pair_file.sv
// tb/tb_reg_pair_file.sv - self-checking bench for reg_pair_file with a behavioural pair model
module tb_reg_pair_file;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  sel;
  logic        rd, wr;
  logic [7:0]  bus_drv;
  logic        bus_en;
  wire  [7:0]  bus_io;
  logic [1:0]  psel;
  logic        pwr;
  logic [15:0] pd;
  logic        inc, dec, xchg;
  logic [15:0] pair_o;
  logic        zero_o, collision_o;

  int n_chk  = 0;
  int n_pass = 0;

  logic [15:0] m_pair [4];
  logic        m_zero, m_coll;

  always #5 clk = ~clk;

  assign bus_io = bus_en ? bus_drv : 8'bz;

  reg_pair_file dut (
    .clk50M_i    (clk),
    .rst_ni      (rst_n),
    .sel_i       (sel),
    .rd_i        (rd),
    .wr_i        (wr),
    .bus_io      (bus_io),
    .pair_sel_i  (psel),
    .pair_wr_i   (pwr),
    .pair_d_i    (pd),
    .inc_i       (inc),
    .dec_i       (dec),
    .xchg_i      (xchg),
    .pair_o      (pair_o),
    .zero_o      (zero_o),
    .collision_o (collision_o)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
  endtask

  task automatic chk_z(input string name, input bit is_z);
    n_chk++;
    if (is_z) n_pass++;
    else $display("FAIL %s: bus high-Z=%0d required=1 at %0t", name, is_z, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_pair[i] = 16'h0000;
    m_zero = 1'b0;
    m_coll = 1'b0;
  endtask

  // One clock of the specified behaviour, from the inputs held across the edge.
  task automatic model_step();
    logic [15:0] nx [4];
    logic [3:0]  hit;
    int          bp;
    nx  = m_pair;
    hit = 4'b0000;
    if (pwr) begin
      nx[psel] = pd;
      hit[psel] = 1'b1;
    end else if (inc) begin
      nx[psel] = m_pair[psel] + 16'd1;
      hit[psel] = 1'b1;
      m_zero = (nx[psel] == 16'd0);
    end else if (dec) begin
      nx[psel] = m_pair[psel] - 16'd1;
      hit[psel] = 1'b1;
      m_zero = (nx[psel] == 16'd0);
    end else if (xchg) begin
      nx[1] = m_pair[2];
      nx[2] = m_pair[1];
      hit   = 4'b0110;
    end
    m_coll = 1'b0;
    if (wr && !rd) begin
      bp = int'(sel) / 2;
      if (hit[bp]) m_coll = 1'b1;
      else if (sel[0]) nx[bp][7:0] = bus_drv;
      else nx[bp][15:8] = bus_drv;
    end
    m_pair = nx;
  endtask

  task automatic drive(input logic [2:0] s, input logic r, input logic w, input logic [7:0] b,
                       input logic [1:0] ps, input logic pw, input logic [15:0] d,
                       input logic i, input logic dc, input logic x);
    sel = s; rd = r; wr = w; bus_drv = b; bus_en = w && !r;
    psel = ps; pwr = pw; pd = d; inc = i; dec = dc; xchg = x;
    @(posedge clk);
    model_step();
    @(negedge clk);
    #1;
  endtask

  // Every falling edge: DUT outputs against the model.
  always @(negedge clk) begin
    chk("pair_o", pair_o, m_pair[psel]);
    chk("zero_o", {15'd0, zero_o}, {15'd0, m_zero});
    chk("collision_o", {15'd0, collision_o}, {15'd0, m_coll});
    if (rd && rst_n) chk("bus_rd", {8'd0, bus_io}, {8'd0, sel[0] ? m_pair[sel[2:1]][7:0] : m_pair[sel[2:1]][15:8]});
    else if (!bus_en) chk_z("bus_z", bus_io === 8'bz);
  end

  initial begin
    rst_n = 1'b0;
    sel = 3'd0; rd = 1'b1; wr = 1'b0; bus_drv = 8'h00; bus_en = 1'b0;
    psel = 2'd0; pwr = 1'b0; pd = 16'h0000; inc = 1'b0; dec = 1'b0; xchg = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_pair", pair_o, 16'h0000);
    chk("rst_zero", {15'd0, zero_o}, 16'd0);
    chk("rst_coll", {15'd0, collision_o}, 16'd0);
    chk_z("rst_bus_rd", bus_io === 8'bz);
    rd = 1'b0;
    rst_n = 1'b1;

    // Byte writes then byte read
    drive(3'd0, 0, 1, 8'h12, 2'd0, 0, 16'h0, 0, 0, 0);
    drive(3'd1, 0, 1, 8'h34, 2'd0, 0, 16'h0, 0, 0, 0);
    drive(3'd0, 1, 0, 8'h00, 2'd0, 0, 16'h0, 0, 0, 0);
    chk("t33_bus", {8'd0, bus_io}, 16'h0012);
    chk("t33_pair", pair_o, 16'h1234);

    // Wraparound on HL with zero flag
    drive(3'd0, 0, 0, 8'h00, 2'd2, 1, 16'hFFFF, 0, 0, 0);
    drive(3'd0, 0, 0, 8'h00, 2'd2, 0, 16'h0, 1, 0, 0);
    chk("t34_inc", pair_o, 16'h0000);
    chk("t34_zero1", {15'd0, zero_o}, 16'd1);
    drive(3'd0, 0, 0, 8'h00, 2'd2, 0, 16'h0, 0, 1, 0);
    chk("t34_dec", pair_o, 16'hFFFF);
    chk("t34_zero0", {15'd0, zero_o}, 16'd0);

    // Exchange with zero flag held high across loads and xchg
    drive(3'd0, 0, 0, 8'h00, 2'd3, 1, 16'hFFFF, 0, 0, 0);
    drive(3'd0, 0, 0, 8'h00, 2'd3, 0, 16'h0, 1, 0, 0);
    drive(3'd0, 0, 0, 8'h00, 2'd1, 1, 16'h1111, 0, 0, 0);
    drive(3'd0, 0, 0, 8'h00, 2'd2, 1, 16'h2222, 0, 0, 0);
    drive(3'd0, 0, 0, 8'h00, 2'd1, 0, 16'h0, 0, 0, 1);
    chk("t35_de", pair_o, 16'h2222);
    psel = 2'd2;
    #1;
    chk("t35_hl", pair_o, 16'h1111);
    chk("t35_zero", {15'd0, zero_o}, 16'd1);

    // Collision with inc on BC, then a non-colliding write to DE
    drive(3'd0, 0, 0, 8'h00, 2'd0, 1, 16'h00FF, 0, 0, 0);
    drive(3'd1, 0, 1, 8'hAA, 2'd0, 0, 16'h0, 1, 0, 0);
    chk("t36_bc", pair_o, 16'h0100);
    chk("t36_coll", {15'd0, collision_o}, 16'd1);
    drive(3'd0, 0, 0, 8'h00, 2'd0, 0, 16'h0, 0, 0, 0);
    chk("t36_coll_clr", {15'd0, collision_o}, 16'd0);
    drive(3'd0, 0, 0, 8'h00, 2'd0, 1, 16'h00FF, 0, 0, 0);
    drive(3'd2, 0, 1, 8'hAA, 2'd0, 0, 16'h0, 1, 0, 0);
    chk("t36_bc2", pair_o, 16'h0100);
    chk("t36_nocoll", {15'd0, collision_o}, 16'd0);
    psel = 2'd1;
    #1;
    chk("t36_de", pair_o, 16'hAA22);

    // Priority: load beats inc; inc beats dec
    drive(3'd0, 0, 0, 8'h00, 2'd3, 1, 16'h5A5A, 1, 0, 0);
    chk("t37_load", pair_o, 16'h5A5A);
    drive(3'd0, 0, 0, 8'h00, 2'd0, 1, 16'h0010, 0, 0, 0);
    drive(3'd0, 0, 0, 8'h00, 2'd0, 0, 16'h0, 1, 1, 0);
    chk("t37_incdec", pair_o, 16'h0011);

    // Write ignored during read, so no collision with the inc on the same pair
    drive(3'd1, 1, 1, 8'h00, 2'd0, 0, 16'h0, 1, 0, 0);
    chk("rdwr_pair", pair_o, 16'h0012);
    chk("rdwr_nocoll", {15'd0, collision_o}, 16'd0);

    // Borrow across byte boundary and underflow
    drive(3'd0, 0, 0, 8'h00, 2'd0, 1, 16'h0100, 0, 0, 0);
    drive(3'd0, 0, 0, 8'h00, 2'd0, 0, 16'h0, 0, 1, 0);
    chk("borrow", pair_o, 16'h00FF);
    drive(3'd0, 0, 0, 8'h00, 2'd0, 1, 16'h0000, 0, 0, 0);
    drive(3'd0, 0, 0, 8'h00, 2'd0, 0, 16'h0, 0, 1, 0);
    chk("underflow", pair_o, 16'hFFFF);

    // Mixed vectors checked against the model every cycle
    for (int k = 0; k < 60; k++) begin
      drive(3'($urandom_range(0, 7)), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
            8'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 5) == 0), 16'($urandom),
            1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0));
    end

    // Mid-cycle reset while reading
    drive(3'd0, 0, 0, 8'h00, 2'd0, 1, 16'hFFFF, 0, 0, 0);
    drive(3'd0, 0, 0, 8'h00, 2'd0, 0, 16'h0, 1, 0, 0);
    drive(3'd0, 0, 0, 8'h00, 2'd1, 1, 16'h1357, 0, 0, 0);
    chk("t38_pre_zero", {15'd0, zero_o}, 16'd1);
    sel = 3'd2; rd = 1'b1; wr = 1'b0; bus_en = 1'b0;
    psel = 2'd1; pwr = 1'b0; inc = 1'b0; dec = 1'b0; xchg = 1'b0;
    @(posedge clk);
    model_step();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_z("t38_bus", bus_io === 8'bz);
    chk("t38_zero", {15'd0, zero_o}, 16'd0);
    chk("t38_coll", {15'd0, collision_o}, 16'd0);
    for (int p = 0; p < 4; p++) begin
      psel = 2'(p);
      #0.25;
      chk($sformatf("t38_pair%0d", p), pair_o, 16'h0000);
    end
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    drive(3'd2, 1, 0, 8'h00, 2'd1, 0, 16'h0, 0, 0, 0);
    chk("t38_after", pair_o, 16'h0000);
    chk("t38_after_bus", {8'd0, bus_io}, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
